// File: rtl/prbs_checker.sv
// PRBS checker for the 8-bit LFSR stream s' = {s[0]^s[2]^s[3]^s[4], s[7:1]}.
// Self-synchronises (FILL/TRAIN), then flywheels in LOCKED and counts bit errors.
module prbs_checker #(
  parameter int unsigned LOCK_MATCHES = 16,
  parameter int unsigned LOSS_ERRS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_valid,
  input  logic       din,
  input  logic       clr_err,
  output logic       locked,
  output logic       bit_err,
  output logic [7:0] err_cnt,
  output logic [7:0] seg0,
  output logic [7:0] seg1
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_MATCHES);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_ERRS);

  state_t     state, state_nxt;
  logic [7:0] h, h_nxt;
  logic [2:0] fill_cnt, fill_cnt_nxt;
  logic [7:0] match_cnt, match_cnt_nxt;
  logic [3:0] consec_err, consec_err_nxt;
  logic [7:0] err_cnt_nxt;
  logic       bit_err_nxt;
  logic       locked_nxt;

  logic       pred;
  logic       mismatch;
  logic       train_hit;
  logic [7:0] match_inc;
  logic [3:0] err_inc;

  assign pred      = h[0] ^ h[2] ^ h[3] ^ h[4];
  assign mismatch  = (din != pred);
  // An all-zero history predicts zeros forever, so it must never count toward lock.
  assign train_hit = !mismatch && (h != 8'h00);
  assign match_inc = match_cnt + 8'd1;
  assign err_inc   = consec_err + 4'd1;

  // State register plus datapath registers; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      h          <= 8'h00;
      fill_cnt   <= 3'd0;
      match_cnt  <= 8'd0;
      consec_err <= 4'd0;
      err_cnt    <= 8'd0;
      bit_err    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed below.
      state      <= state_nxt;
      h          <= h_nxt;
      fill_cnt   <= fill_cnt_nxt;
      match_cnt  <= match_cnt_nxt;
      consec_err <= consec_err_nxt;
      err_cnt    <= err_cnt_nxt;
      bit_err    <= bit_err_nxt;
      locked     <= locked_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through this block leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (din_valid) begin
      case (state)
        FILL:    if (fill_cnt == 3'd7) state_nxt = TRAIN;
        TRAIN:   if (train_hit && (match_inc == LOCK_TGT)) state_nxt = LOCKED;
        LOCKED:  if (mismatch && (err_inc == LOSS_TGT)) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Datapath next values; registered outputs are derived here so they carry no comb path.
  always_comb begin
    h_nxt          = h;
    fill_cnt_nxt   = fill_cnt;
    match_cnt_nxt  = match_cnt;
    consec_err_nxt = consec_err;
    err_cnt_nxt    = err_cnt;
    bit_err_nxt    = 1'b0;
    if (din_valid) begin
      case (state)
        FILL: begin
          h_nxt         = {din, h[7:1]};
          fill_cnt_nxt  = fill_cnt + 3'd1;
          match_cnt_nxt = 8'd0;
        end
        TRAIN: begin
          h_nxt          = {din, h[7:1]};
          match_cnt_nxt  = train_hit ? match_inc : 8'd0;
          consec_err_nxt = 4'd0;
        end
        LOCKED: begin
          // Flywheel: shift the prediction so a corrupted bit never pollutes the history.
          h_nxt = {pred, h[7:1]};
          if (mismatch) begin
            bit_err_nxt    = 1'b1;
            err_cnt_nxt    = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            consec_err_nxt = err_inc;
            if (err_inc == LOSS_TGT) begin
              h_nxt        = 8'h00;
              fill_cnt_nxt = 3'd0;
            end
          end else begin
            consec_err_nxt = 4'd0;
          end
        end
        default: ;
      endcase
    end
    if (clr_err) err_cnt_nxt = 8'd0;
  end

  assign locked_nxt = (state_nxt == LOCKED);

  // Output decode: active-low glyph {a,b,c,d,e,f,g,dp}, dp always off.
  function automatic logic [7:0] seg_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0: g = 8'h03;
      4'h1: g = 8'h9F;
      4'h2: g = 8'h25;
      4'h3: g = 8'h0D;
      4'h4: g = 8'h99;
      4'h5: g = 8'h49;
      4'h6: g = 8'h41;
      4'h7: g = 8'h1F;
      4'h8: g = 8'h01;
      4'h9: g = 8'h09;
      4'hA: g = 8'h11;
      4'hB: g = 8'hC1;
      4'hC: g = 8'h63;
      4'hD: g = 8'h85;
      4'hE: g = 8'h61;
      default: g = 8'h71;
    endcase
    return g;
  endfunction

  always_comb begin
    seg0 = seg_glyph(err_cnt[3:0]);
    seg1 = seg_glyph(err_cnt[7:4]);
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: reset, lock acquisition with gaps, single/burst
// errors, loss and relock, saturation, clear-on-error, mid-state reset, all-zero stream.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       clr_err = 1'b0;
  logic       locked;
  logic       bit_err;
  logic [7:0] err_cnt;
  logic [7:0] seg0;
  logic [7:0] seg1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] lfsr;

  prbs_checker #(.LOCK_MATCHES(16), .LOSS_ERRS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clr_err   (clr_err),
    .locked    (locked),
    .bit_err   (bit_err),
    .err_cnt   (err_cnt),
    .seg0      (seg0),
    .seg1      (seg1)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic d, input logic c);
    din_valid = v;
    din       = d;
    clr_err   = c;
    @(posedge clk);
    #1;
  endtask

  // Send the next reference bit, optionally inverted, and advance the model LFSR.
  task automatic send_bit(input logic inv, input logic clr);
    step(1'b1, lfsr[0] ^ inv, clr);
    lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
  endtask

  task automatic idle_gaps();
    logic r;
    repeat ($urandom_range(0, 2)) begin
      r = 1'($urandom_range(0, 1));
      step(1'b0, r, 1'b0);
      check1("gap_bit_err", bit_err, 1'b0);
    end
  endtask

  initial begin
    // Reset, then idle.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check1("rst_locked", locked, 1'b0);
    check1("rst_bit_err", bit_err, 1'b0);
    check8("rst_err_cnt", err_cnt, 8'h00);
    check8("rst_seg0", seg0, 8'h03);
    check8("rst_seg1", seg1, 8'h03);

    // Clean stream from seed 01 with random valid gaps: lock right after bit 24.
    lfsr = 8'h01;
    for (int i = 1; i <= 24; i++) begin
      idle_gaps();
      send_bit(1'b0, 1'b0);
      check1("acq_locked", locked, i == 24);
    end
    idle_gaps();
    check1("acq_hold_locked", locked, 1'b1);
    check8("acq_err_cnt", err_cnt, 8'h00);

    // Single inverted bit while locked.
    repeat (5) begin
      send_bit(1'b0, 1'b0);
      check1("pre_err_bit_err", bit_err, 1'b0);
    end
    send_bit(1'b1, 1'b0);
    check1("single_bit_err", bit_err, 1'b1);
    check8("single_err_cnt", err_cnt, 8'h01);
    check8("single_seg0", seg0, 8'h9F);
    check8("single_seg1", seg1, 8'h03);
    check1("single_locked", locked, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check1("single_pulse_end", bit_err, 1'b0);
    send_bit(1'b0, 1'b0);
    check1("single_after_bit_err", bit_err, 1'b0);
    check8("single_after_err_cnt", err_cnt, 8'h01);

    // Clear, then three consecutive errors drop lock on the third.
    step(1'b0, 1'b0, 1'b1);
    check8("clr_err_cnt", err_cnt, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      send_bit(1'b1, 1'b0);
      check1("burst_bit_err", bit_err, 1'b1);
      check8("burst_err_cnt", err_cnt, 8'(i));
      check1("burst_locked", locked, i < 3);
    end
    for (int i = 1; i <= 24; i++) begin
      send_bit(1'b0, 1'b0);
      check1("relock_locked", locked, i == 24);
      check1("relock_bit_err", bit_err, 1'b0);
    end
    check8("relock_err_cnt", err_cnt, 8'h03);

    // 300 isolated errors: saturate at 255.
    for (int i = 1; i <= 300; i++) begin
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      if (i == 100) begin
        check8("sat_mid_err_cnt", err_cnt, 8'h67);
        check8("sat_mid_seg0", seg0, 8'h1F);
        check8("sat_mid_seg1", seg1, 8'h41);
      end
    end
    check8("sat_err_cnt", err_cnt, 8'hFF);
    check8("sat_seg0", seg0, 8'h71);
    check8("sat_seg1", seg1, 8'h71);
    check1("sat_locked", locked, 1'b1);

    // Clear coincident with an error.
    send_bit(1'b1, 1'b1);
    check8("clr_coinc_err_cnt", err_cnt, 8'h00);
    check1("clr_coinc_bit_err", bit_err, 1'b1);
    check8("clr_coinc_seg0", seg0, 8'h03);
    send_bit(1'b0, 1'b0);
    check1("clr_after_bit_err", bit_err, 1'b0);
    check8("clr_after_err_cnt", err_cnt, 8'h00);

    // Reset mid-LOCKED beats a coincident error.
    send_bit(1'b1, 1'b0);
    check8("pre_rst_err_cnt", err_cnt, 8'h01);
    rst = 1'b1;
    send_bit(1'b1, 1'b0);
    rst = 1'b0;
    check1("rst_lk_locked", locked, 1'b0);
    check1("rst_lk_bit_err", bit_err, 1'b0);
    check8("rst_lk_err_cnt", err_cnt, 8'h00);
    check8("rst_lk_seg1", seg1, 8'h03);

    // Reset mid-TRAIN restarts acquisition from scratch.
    repeat (12) send_bit(1'b0, 1'b0);
    check1("mid_train_locked", locked, 1'b0);
    rst = 1'b1;
    send_bit(1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      send_bit(1'b0, 1'b0);
      check1("rst_tr_locked", locked, i == 24);
    end

    // All-zero stream never locks and never counts.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check1("zero_locked", locked, 1'b0);
      check1("zero_bit_err", bit_err, 1'b0);
    end
    check8("zero_err_cnt", err_cnt, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL provide parameter LOCK_MATCHES, default 16, consecutive correct predictions required to declare lock (range 1..255).
REQ-002 SHALL provide parameter LOSS_ERRS, default 3, consecutive mismatches while locked that drop lock (range 1..15).
REQ-003 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port din_valid, input, 1, qualifies din; a cycle with din_valid=1 is one received bit.
REQ-006 SHALL have port din, input, 1, received serial PRBS bit.
REQ-007 SHALL have port clr_err, input, 1, synchronous clear of err_cnt.
REQ-008 SHALL have port locked, output, 1, high while in LOCKED state.
REQ-009 SHALL have port bit_err, output, 1, one-cycle pulse per counted bit error.
REQ-010 SHALL have port err_cnt, output, 8, saturating error count.
REQ-011 SHALL have port seg0, output, 8, active-low 7-seg glyph of err_cnt[3:0].
REQ-012 SHALL have port seg1, output, 8, active-low 7-seg glyph of err_cnt[7:4].

Function
REQ-013 Reference sequence SHALL be the 8-bit LFSR: state s, emitted bit s[0], next s = {s[0]^s[2]^s[3]^s[4], s[7:1]}; the checked stream is the emitted bits.
REQ-014 Checker SHALL keep an 8-bit history h, updated h <= {bit_in, h[7:1]}; prediction pred = h[0]^h[2]^h[3]^h[4], computed from h before the update.
REQ-015 Cycles with din_valid=0 SHALL change no state except clr_err, and SHALL drive bit_err=0.
REQ-016 FSM states SHALL be FILL, TRAIN, LOCKED; locked=1 only in LOCKED.
REQ-017 FILL: each valid bit SHALL shift din into h and increment fill_cnt; on the 8th valid bit, next state TRAIN, match_cnt=0.
REQ-018 TRAIN: each valid bit SHALL shift din into h; if din==pred and h!=0, match_cnt increments, else match_cnt clears to 0.
REQ-019 TRAIN: when match_cnt reaches LOCK_MATCHES, next state SHALL be LOCKED with consec_err=0; no errors are counted in FILL or TRAIN.
REQ-020 LOCKED: each valid bit SHALL shift pred (not din) into h (flywheel), so one corrupted bit causes exactly one mismatch.
REQ-021 LOCKED mismatch (din!=pred): bit_err=1 next cycle, err_cnt+1 saturating at 255, consec_err+1.
REQ-022 LOCKED match: consec_err SHALL clear to 0.
REQ-023 When consec_err reaches LOSS_ERRS, next state SHALL be FILL with fill_cnt=0 and h=0; locked falls the cycle after the LOSS_ERRS-th error; that error is still counted.
REQ-024 clr_err=1 SHALL set err_cnt=0 next cycle; clr_err coincident with an error SHALL leave err_cnt=0 while bit_err still pulses.
REQ-025 All outputs except seg0/seg1 SHALL be registered; seg0/seg1 SHALL be combinational decode of registered err_cnt (zero added latency).
REQ-026 Glyph bits SHALL be [7]=a..[1]=g, [0]=dp; dp always off (1); values 0..F = 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (hex).

Reset
REQ-027 rst=1 SHALL force state FILL, h=0, fill_cnt=match_cnt=consec_err=0, err_cnt=0, locked=0, bit_err=0, so seg0=seg1=8'h03.
REQ-028 rst SHALL take priority over din_valid and clr_err, including mid-TRAIN and mid-LOCKED.

Verification
REQ-029 Reset then idle -> locked=0, bit_err=0, err_cnt=0, seg0=seg1=8'h03.
REQ-030 Clean stream from seed 8'h01, with random din_valid gaps -> locked=1 the cycle after the 24th valid bit (8 fill + 16 matches); err_cnt stays 0.
REQ-031 Locked, invert one bit -> single bit_err pulse, err_cnt=1, seg0=8'h9F, seg1=8'h03, locked stays 1.
REQ-032 Locked, invert 3 consecutive valid bits -> err_cnt=3, locked=0 the cycle after the 3rd; 24 further clean bits -> locked=1.
REQ-033 All-zero stream for 100 valid bits -> locked stays 0, err_cnt stays 0.
REQ-034 Locked, 300 isolated single-bit errors (separated by >=1 good bit) -> err_cnt=255, seg0=seg1=8'h71; then clr_err coincident with an error -> err_cnt=0, bit_err=1.
